// File: rtl/fpu_lib.sv
// fpu_lib: shared fp16 types, opcodes, condition-code and status-flag layouts.
package fpu_lib;
   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] frac;
   } fp16_t;
   typedef enum logic [2:0] {FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_SQRT, FPU_CMP, FPU_CVT, FPU_NOP} fpuOp_t;
   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } condCode_t;
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } statusFlag_t;
   localparam logic [15:0] FP16_QNAN = 16'h7E00;
   localparam int EXP_BIAS = 15;
   localparam logic [4:0] EXP_MAX = 5'd31;
endpackage

// File: rtl/fpu_lzc16.sv
// fpu_lzc16: leading-zero count of a 16-bit word (16 when all zero).
module fpu_lzc16 (
   input  logic [15:0] a,
   output logic [4:0]  cnt
);
   always_comb begin
      cnt = 5'd16;
      for (int i = 0; i < 16; i++) cnt = a[i] ? 5'(15 - i) : cnt;
   end
endmodule

// File: rtl/fpu_add_sub16.sv
// fpu_add_sub16: fp16 add/subtract, round-to-nearest-even, registered result with ZCNV and IEEE flags.
module fpu_add_sub16
   import fpu_lib::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        sub,
   input  fp16_t       fpuIn1,
   input  fp16_t       fpuIn2,
   input  fpuOp_t      op,
   output fp16_t       fpuOut,
   output condCode_t   condCodes,
   output statusFlag_t statusFlags
);
   logic bs, swap, eff_add, xs, a_nan, b_nan, a_inf, b_inf, snan, rnd, nx, of, zero, sign;
   fp16_t x, y, res;
   condCode_t cc;
   statusFlag_t fl;
   logic [4:0] ex, ey, d, lz, sh, e;
   logic [13:0] ma, mb0, mb, diff, m;
   logic [14:0] sum, mag;
   logic [15:0] r16;
   logic unused_op;
   assign unused_op = ^op;
   // align: swap so x has the larger magnitude, then shift y right keeping a sticky bit
   always_comb begin
      bs = fpuIn2.sign ^ sub;
      swap = fpuIn2[14:0] > fpuIn1[14:0];
      x = swap ? fpuIn2 : fpuIn1;
      y = swap ? fpuIn1 : fpuIn2;
      xs = swap ? bs : fpuIn1.sign;
      eff_add = fpuIn1.sign == bs;
      ex = x.exp == 5'd0 ? 5'd1 : x.exp;
      ey = y.exp == 5'd0 ? 5'd1 : y.exp;
      ma = {|x.exp, x.frac, 3'b000};
      mb0 = {|y.exp, y.frac, 3'b000};
      d = ex - ey;
      mb = d >= 5'd14 ? {13'd0, |mb0} : (mb0 >> d) | {13'd0, |(mb0 & ~(14'h3fff << d))};
      sum = {1'b0, ma} + {1'b0, mb};
      diff = ma - mb;
   end
   fpu_lzc16 u_lzc (.a({diff, 2'b11}), .cnt(lz));
   always_comb begin
      sh = lz > ex - 5'd1 ? ex - 5'd1 : lz;
      m = eff_add ? (sum[14] ? {sum[14:2], |sum[1:0]} : sum[13:0]) : diff << sh;
      e = eff_add ? ex + {4'd0, sum[14]} : ex - sh;
      rnd = m[2] & (m[3] | m[1] | m[0]);
      // rounding carry ripples from the fraction into the exponent field
      r16 = {1'b0, m[13] ? e : 5'd0, m[12:3]} + {15'd0, rnd};
      of = r16 >= {1'b0, EXP_MAX, 10'd0};
      nx = |m[2:0] | of;
      mag = of ? {EXP_MAX, 10'd0} : r16[14:0];
      zero = mag == 15'd0;
      sign = xs & ~(zero & ~eff_add);
      a_nan = fpuIn1.exp == EXP_MAX && fpuIn1.frac != 10'd0;
      b_nan = fpuIn2.exp == EXP_MAX && fpuIn2.frac != 10'd0;
      a_inf = fpuIn1.exp == EXP_MAX && fpuIn1.frac == 10'd0;
      b_inf = fpuIn2.exp == EXP_MAX && fpuIn2.frac == 10'd0;
      snan = (a_nan & ~fpuIn1.frac[9]) | (b_nan & ~fpuIn2.frac[9]);
      res = {sign, mag};
      cc = {zero, eff_add & sum[14], sign, of};
      fl = {2'b00, of, ~|mag[14:10] & nx, nx};
      if (a_nan | b_nan | (a_inf & b_inf & ~eff_add)) begin
         res = FP16_QNAN;
         cc = '0;
         fl = {(a_nan | b_nan) ? snan : 1'b1, 4'b0000};
      end else if (a_inf | b_inf) begin
         res = {a_inf ? fpuIn1.sign : bs, EXP_MAX, 10'd0};
         cc = {2'b00, res.sign, 1'b0};
         fl = '0;
      end
   end
   always_ff @(posedge clk) begin
      fpuOut <= rst ? '0 : res;
      condCodes <= rst ? '0 : cc;
      statusFlags <= rst ? '0 : fl;
   end
endmodule

// File: tb/tb_fpu_add_sub16.sv
// tb_fpu_add_sub16: random and directed checks of fpu_add_sub16 against an exact-arithmetic fp16 model.
module tb_fpu_add_sub16;
   import fpu_lib::*;
   logic clk = 1'b0, rst = 1'b1, sub = 1'b0, run = 1'b0;
   logic [15:0] in1 = '0, in2 = '0;
   fpuOp_t op = FPU_ADD;
   fp16_t out;
   condCode_t cc;
   statusFlag_t fl;
   logic [24:0] exp_q;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   fpu_add_sub16 dut (.clk(clk), .rst(rst), .sub(sub), .fpuIn1(in1), .fpuIn2(in2), .op(op),
                      .fpuOut(out), .condCodes(cc), .statusFlags(fl));
   // exact value in units of 2^-24, then round-to-nearest-even back to fp16
   function automatic logic [24:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
      logic sa, sb, sg, c, nx, of, uf, up;
      int ea, eb, e;
      longint va, vb, v, av, q, rem, half;
      logic [15:0] r;
      sa = a[15];
      sb = b[15] ^ s;
      if ((a[14:10] == 5'd31 && a[9:0] != 0) || (b[14:10] == 5'd31 && b[9:0] != 0))
         return {16'h7E00, 4'b0000, ((a[14:10] == 5'd31 && a[9:0] != 0 && !a[9]) ||
                                     (b[14:10] == 5'd31 && b[9:0] != 0 && !b[9])), 4'b0000};
      if (a[14:0] == 15'h7C00 && b[14:0] == 15'h7C00 && sa != sb) return {16'h7E00, 4'b0000, 5'b10000};
      if (a[14:0] == 15'h7C00) return {sa, 15'h7C00, 2'b00, sa, 1'b0, 5'b00000};
      if (b[14:0] == 15'h7C00) return {sb, 15'h7C00, 2'b00, sb, 1'b0, 5'b00000};
      ea = a[14:10] == 0 ? 1 : int'(a[14:10]);
      eb = b[14:10] == 0 ? 1 : int'(b[14:10]);
      va = longint'({a[14:10] != 0, a[9:0]}) << (ea - 1);
      vb = longint'({b[14:10] != 0, b[9:0]}) << (eb - 1);
      v = (sa ? -va : va) + (sb ? -vb : vb);
      av = v < 0 ? -v : v;
      c = (sa == sb) && (av >= (longint'(2048) << ((ea > eb ? ea : eb) - 1)));
      if (v == 0) begin
         sg = (sa == sb) ? sa : 1'b0;
         return {sg, 15'd0, 1'b1, 1'b0, sg, 1'b0, 5'b00000};
      end
      sg = v < 0;
      e = 1;
      while (av >= (longint'(2048) << (e - 1))) e++;
      q = av >> (e - 1);
      rem = av - (q << (e - 1));
      half = e > 1 ? longint'(1) << (e - 2) : 0;
      up = rem > half || (rem == half && rem != 0 && q[0]);
      q = q + (up ? 1 : 0);
      if (q == 2048) begin
         q = 1024;
         e++;
      end
      nx = rem != 0;
      of = e >= 31;
      if (of) begin
         r = {sg, 15'h7C00};
         nx = 1'b1;
      end else r = {sg, q >= 1024 ? 5'(e) : 5'd0, q[9:0]};
      uf = r[14:10] == 0 && nx;
      return {r, r[14:0] == 0, c, sg, of, 1'b0, 1'b0, of, uf, nx};
   endfunction
   task automatic check(input string name, input logic [24:0] got, input logic [24:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h/%b/%b want=%h/%b/%b", name, got[24:9], got[8:5], got[4:0],
                  want[24:9], want[8:5], want[4:0]);
      end
   endtask
   always @(posedge clk) exp_q <= rst ? 25'd0 : model(in1, in2, sub);
   always @(negedge clk)
      if (run) begin
         total++;
         if ({out, cc, fl} !== exp_q) begin
            bad++;
            $display("FAIL stream in1=%h in2=%h sub=%b got=%h/%b/%b want=%h/%b/%b", in1, in2, sub,
                     out, cc, fl, exp_q[24:9], exp_q[8:5], exp_q[4:0]);
         end
      end
   typedef struct {
      logic [15:0] a, b;
      logic        s;
      logic [24:0] want;
   } vec_t;
   vec_t vecs[16] = '{
      '{16'h3C00, 16'h0000, 1'b0, {16'h3C00, 4'b0000, 5'b00000}},
      '{16'h4000, 16'h3C00, 1'b0, {16'h4200, 4'b0000, 5'b00000}},
      '{16'h4400, 16'h4000, 1'b0, {16'h4600, 4'b0000, 5'b00000}},
      '{16'h4400, 16'h4C40, 1'b0, {16'h4D40, 4'b0000, 5'b00000}},
      '{16'h5EF0, 16'h621E, 1'b0, {16'h64CB, 4'b0100, 5'b00000}},
      '{16'h3C00, 16'h3C00, 1'b1, {16'h0000, 4'b1000, 5'b00000}},
      '{16'h3C00, 16'h4000, 1'b1, {16'hBC00, 4'b0010, 5'b00000}},
      '{16'h4900, 16'h4200, 1'b1, {16'h4700, 4'b0000, 5'b00000}},
      '{16'h5E38, 16'h5280, 1'b1, {16'h5D68, 4'b0000, 5'b00000}},
      '{16'hBC00, 16'h3C00, 1'b0, {16'h0000, 4'b1000, 5'b00000}},
      '{16'hBC00, 16'h4500, 1'b0, {16'h4400, 4'b0000, 5'b00000}},
      '{16'hEA45, 16'h6CE7, 1'b0, {16'h6712, 4'b0000, 5'b00000}},
      '{16'hDEF0, 16'h7062, 1'b0, {16'h702A, 4'b0000, 5'b00001}},
      '{16'h7BFF, 16'h7BFF, 1'b0, {16'h7C00, 4'b0101, 5'b00101}},
      '{16'h7C00, 16'h7C00, 1'b1, {16'h7E00, 4'b0000, 5'b10000}},
      '{16'h0001, 16'h0001, 1'b0, {16'h0002, 4'b0000, 5'b00000}}
   };
   initial begin
      logic [15:0] r1, r2;
      @(posedge clk);
      #1;
      run = 1'b1;
      check("reset", {out, cc, fl}, 25'd0);
      rst = 1'b0;
      foreach (vecs[i]) begin
         in1 = vecs[i].a;
         in2 = vecs[i].b;
         sub = vecs[i].s;
         op = vecs[i].s ? FPU_SUB : FPU_ADD;
         check($sformatf("model_%0d", i), model(vecs[i].a, vecs[i].b, vecs[i].s), vecs[i].want);
         @(posedge clk);
         #1;
         check($sformatf("dut_%0d", i), {out, cc, fl}, vecs[i].want);
      end
      for (int i = 0; i < 3000; i++) begin
         r1 = 16'($urandom);
         r2 = 16'($urandom);
         in1 = r2[2:0] == 3'd0 ? {r1[15], 3'b000, r2[4:3], r1[9:0]} :
               r2[2:0] == 3'd1 ? {r1[15], 5'd31, r2[8] ? 10'd0 : r1[9:0]} : r1;
         r1 = 16'($urandom);
         in2 = r2[6:5] == 2'd0 ? r1 : {r1[15], in1[14:10] ^ {2'b00, r2[11:9]}, r1[9:0]};
         sub = r2[15];
         op = sub ? FPU_SUB : FPU_ADD;
         if (i == 1500) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("reset_mid", {out, cc, fl}, 25'd0);
            rst = 1'b0;
            in1 = 16'h4000;
            in2 = 16'h3C00;
            sub = 1'b0;
            op = FPU_ADD;
            @(posedge clk);
            #1;
            check("after_reset", {out, cc, fl}, {16'h4200, 4'b0000, 5'b00000});
         end else begin
            @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #1;
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
